regfile_wr_sched: RTL and testbench

Write-port scheduler for the 14×48-bit vector register file. After reset it sequences an initialization pass over every register (clear, then load constants), then shares the single write port (we3/ra3/wd3) between the execute writeback and the colour unit. The colour unit's 8-bit palette code is expanded into two register writes: colour word to r4, alpha to r3. The block sits between the execute stage, the colour decoder and the register file. It replaces the register file's PC-keyed initialization.

---
 rtl/regfile_wr_sched_if.sv | 28 ++
 rtl/regfile_wr_sched.sv | 207 ++++++++++++++++++++
 tb/tb_regfile_wr_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_if.sv
// regfile_wr_sched_if: execute writeback, colour request and register-file
// write-port signals of the write scheduler.
// master = request sources / register-file side, slave = scheduler.
interface regfile_wr_sched_if #(
   parameter int AW = 4,
   parameter int DW = 48
) ();
   logic          ex_valid;
   logic          ex_ready;
   logic [AW-1:0] ex_addr;
   logic [DW-1:0] ex_data;
   logic          col_valid;
   logic          col_ready;
   logic [7:0]    col_code;
   logic          we3;
   logic [AW-1:0] ra3;
   logic [DW-1:0] wd3;

   modport master (
      output ex_valid, ex_addr, ex_data, col_valid, col_code,
      input  ex_ready, col_ready, we3, ra3, wd3
   );

   modport slave (
      input  ex_valid, ex_addr, ex_data, col_valid, col_code,
      output ex_ready, col_ready, we3, ra3, wd3
   );
endinterface

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: write-port scheduler for the vector register file.
// After reset (or init_start) it clears r0..NREGS-1, loads r10..r13 with
// constants, then shares the single write port between execute writeback and
// the colour unit (palette code expanded into an r4 colour word + r3 alpha).
// Build option: define RFSCHED_RR_EN for round-robin arbitration in RUN;
// undefined gives fixed priority, execute over colour.
module regfile_wr_sched #(
   parameter int NREGS     = 14,
   parameter int DW        = 48,
   parameter int AW        = 4,
   parameter int COL_REG   = 4,
   parameter int ALPHA_REG = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic init_start,
   output logic init_done,
   output logic addr_err,
   regfile_wr_sched_if.slave bus
);
   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_CONST = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_COL2  = 2'd3;

   localparam logic [AW:0]   NREGS_W    = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);
   localparam logic [AW-1:0] COL_ADDR   = AW'(COL_REG);
   localparam logic [AW-1:0] ALPHA_ADDR = AW'(ALPHA_REG);

   // 2-bit colour level to 8-bit intensity
   function automatic logic [7:0] col_lvl(input logic [1:0] c);
      case (c)
         2'b00:   col_lvl = 8'd0;
         2'b01:   col_lvl = 8'd63;
         2'b10:   col_lvl = 8'd191;
         default: col_lvl = 8'd255;
      endcase
   endfunction

   // 2-bit alpha level to alpha value
   function automatic logic [6:0] alpha_lvl(input logic [1:0] c);
      case (c)
         2'b00:   alpha_lvl = 7'd0;
         2'b01:   alpha_lvl = 7'd25;
         2'b10:   alpha_lvl = 7'd50;
         default: alpha_lvl = 7'd75;
      endcase
   endfunction

   logic [1:0]    state_reg, state_next;
   logic [AW-1:0] cnt_reg, cnt_next;
   logic [6:0]    alpha_reg, alpha_next;
   logic          we3_reg, we3_next;
   logic [AW-1:0] ra3_reg, ra3_next;
   logic [DW-1:0] wd3_reg, wd3_next;
   logic          err_reg, err_next;
   logic          ex_rdy, col_rdy;
   logic          ex_fire, col_fire;
   logic [47:0]   col_word;

   assign col_word = {col_lvl(bus.col_code[3:2]), col_lvl(bus.col_code[5:4]),
                      col_lvl(bus.col_code[7:6]), col_lvl(bus.col_code[3:2]),
                      col_lvl(bus.col_code[5:4]), col_lvl(bus.col_code[7:6])};

`ifdef RFSCHED_RR_EN
   // last grant: 0 = execute, 1 = colour
   logic last_reg, last_next;

   // RUN arbitration: the requester not granted last wins a tie
   always_comb begin
      ex_rdy  = 1'b0;
      col_rdy = 1'b0;
      if (state_reg == S_RUN && !init_start) begin
         ex_rdy  = !bus.col_valid || last_reg;
         col_rdy = !bus.ex_valid || !last_reg;
      end
   end

   // grant history moves only on a completed handshake
   always_comb begin
      last_next = last_reg;
      if (ex_fire)
         last_next = 1'b0;
      else if (col_fire)
         last_next = 1'b1;
   end

   // last-grant flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_reg <= 1'b0;
      else
         last_reg <= last_next;
   end
`else
   // RUN arbitration: execute always wins, colour only when execute is idle
   always_comb begin
      ex_rdy  = 1'b0;
      col_rdy = 1'b0;
      if (state_reg == S_RUN && !init_start) begin
         ex_rdy  = 1'b1;
         col_rdy = !bus.ex_valid;
      end
   end
`endif

   assign ex_fire  = bus.ex_valid && ex_rdy;
   assign col_fire = bus.col_valid && col_rdy;

   // next state and next write-port contents; ra3/wd3 hold when no write
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      alpha_next = alpha_reg;
      we3_next   = 1'b0;
      ra3_next   = ra3_reg;
      wd3_next   = wd3_reg;
      err_next   = 1'b0;
      if (init_start) begin
         state_next = S_CLEAR;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            S_CLEAR: begin
               we3_next = 1'b1;
               ra3_next = cnt_reg;
               wd3_next = '0;
               if (cnt_reg == LAST_ADDR) begin
                  state_next = S_CONST;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            S_CONST: begin
               we3_next = 1'b1;
               case (cnt_reg[1:0])
                  2'd0:    begin ra3_next = AW'(10); wd3_next = DW'(7'd25);  end
                  2'd1:    begin ra3_next = AW'(11); wd3_next = DW'(7'd100); end
                  2'd2:    begin ra3_next = AW'(12); wd3_next = DW'(7'd4);   end
                  default: begin ra3_next = AW'(13); wd3_next = DW'(7'd3);   end
               endcase
               if (cnt_reg[1:0] == 2'd3) begin
                  state_next = S_RUN;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            S_RUN: begin
               if (ex_fire) begin
                  // out-of-range destination: drop the write, flag it
                  if ({1'b0, bus.ex_addr} >= NREGS_W) begin
                     err_next = 1'b1;
                  end else begin
                     we3_next = 1'b1;
                     ra3_next = bus.ex_addr;
                     wd3_next = bus.ex_data;
                  end
               end else if (col_fire) begin
                  we3_next   = 1'b1;
                  ra3_next   = COL_ADDR;
                  wd3_next   = DW'(col_word);
                  alpha_next = alpha_lvl(bus.col_code[1:0]);
                  state_next = S_COL2;
               end
            end
            default: begin
               we3_next   = 1'b1;
               ra3_next   = ALPHA_ADDR;
               wd3_next   = DW'(alpha_reg);
               state_next = S_RUN;
            end
         endcase
      end
   end

   // state and registered write-port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_CLEAR;
         cnt_reg   <= '0;
         alpha_reg <= '0;
         we3_reg   <= 1'b0;
         ra3_reg   <= '0;
         wd3_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         alpha_reg <= alpha_next;
         we3_reg   <= we3_next;
         ra3_reg   <= ra3_next;
         wd3_reg   <= wd3_next;
         err_reg   <= err_next;
      end
   end

   assign bus.ex_ready  = ex_rdy;
   assign bus.col_ready = col_rdy;
   assign bus.we3       = we3_reg;
   assign bus.ra3       = ra3_reg;
   assign bus.wd3       = wd3_reg;
   assign addr_err      = err_reg;
   assign init_done     = (state_reg == S_RUN);
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed bench for the register-file write scheduler.
// Stimulus pushes the expected write (cycle, address, data or address error)
// into a queue; a negedge monitor pops and compares every write it sees.
module tb_regfile_wr_sched;
   localparam int AW = 4;
   localparam int DW = 48;

   typedef struct {
      int          cyc;
      logic        err;
      logic [3:0]  addr;
      logic [47:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_start = 1'b0;
   logic init_done;
   logic addr_err;

   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   base;
   exp_t q[$];

   regfile_wr_sched_if #(.AW(AW), .DW(DW)) bus ();

   regfile_wr_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .init_done  (init_done),
      .addr_err   (addr_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // posedge counter used to timestamp expected writes
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h (cyc %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int c, input logic e, input logic [3:0] a, input logic [47:0] d);
      exp_t x;
      x.cyc = c; x.err = e; x.addr = a; x.data = d;
      q.push_back(x);
   endtask

   // 18 init writes, the first on the edge after 'b'
   task automatic push_init(input int b);
      for (int i = 0; i < 14; i++) push_wr(b + i + 1, 1'b0, 4'(i), 48'd0);
      push_wr(b + 15, 1'b0, 4'd10, 48'd25);
      push_wr(b + 16, 1'b0, 4'd11, 48'd100);
      push_wr(b + 17, 1'b0, 4'd12, 48'd4);
      push_wr(b + 18, 1'b0, 4'd13, 48'd3);
   endtask

   // RUN must be reached exactly 18 edges after 'b'
   task automatic wait_init(input int b);
      while (cyc < b + 17) step();
      chk("init_done_pre", 48'(init_done), 48'd0);
      chk("ex_ready_init", 48'(bus.ex_ready), 48'd0);
      step();
      chk("init_done", 48'(init_done), 48'd1);
      chk("ex_ready_run", 48'(bus.ex_ready), 48'd1);
      chk("col_ready_run", 48'(bus.col_ready), 48'd1);
   endtask

   task automatic do_ex(input logic [3:0] a, input logic [47:0] d);
      bus.ex_valid = 1'b1; bus.ex_addr = a; bus.ex_data = d;
      #1 chk("ex_ready", 48'(bus.ex_ready), 48'd1);
      push_wr(cyc + 1, (a >= 4'd14), a, d);
      step();
      bus.ex_valid = 1'b0;
   endtask

   task automatic do_col(input logic [7:0] code, input logic [47:0] word, input logic [47:0] alpha);
      bus.col_valid = 1'b1; bus.col_code = code;
      #1 chk("col_ready", 48'(bus.col_ready), 48'd1);
      push_wr(cyc + 1, 1'b0, 4'd4, word);
      push_wr(cyc + 2, 1'b0, 4'd3, alpha);
      step();
      // in COL2: code changes must not matter, both readies low
      bus.col_valid = 1'b0; bus.col_code = 8'h00;
      bus.ex_valid = 1'b1; bus.ex_addr = 4'd9;
      #1 chk("ex_ready_col2", 48'(bus.ex_ready), 48'd0);
      chk("col_ready_col2", 48'(bus.col_ready), 48'd0);
      bus.ex_valid = 1'b0;
      step();
   endtask

   // monitor: every write or address error must match the queue head
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (bus.we3 || addr_err) begin
            if (q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_write: cyc=%0d we3=%0b err=%0b ra3=%0d wd3=%h, required no write",
                        cyc, bus.we3, addr_err, bus.ra3, bus.wd3);
            end else begin
               e = q.pop_front();
               compared++;
               if (e.cyc != cyc || e.err !== addr_err || e.err === bus.we3 ||
                   (!e.err && (bus.ra3 !== e.addr || bus.wd3 !== e.data))) begin
                  mismatched++;
                  $display("FAIL write: cyc=%0d we3=%0b err=%0b ra3=%0d wd3=%h, required cyc=%0d err=%0b ra3=%0d wd3=%h",
                           cyc, bus.we3, addr_err, bus.ra3, bus.wd3, e.cyc, e.err, e.addr, e.data);
               end else begin
                  $display("write ok: cyc=%0d err=%0b ra3=%0d wd3=%h", cyc, addr_err, bus.ra3, bus.wd3);
               end
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            compared++; mismatched++;
            $display("FAIL missing_write: cyc=%0d saw none, required cyc=%0d err=%0b ra3=%0d wd3=%h",
                     cyc, e.cyc, e.err, e.addr, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ex_valid = 1'b0; bus.ex_addr = '0; bus.ex_data = '0;
      bus.col_valid = 1'b0; bus.col_code = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we3", 48'(bus.we3), 48'd0);
      chk("rst_ra3", 48'(bus.ra3), 48'd0);
      chk("rst_wd3", bus.wd3, 48'd0);
      chk("rst_init_done", 48'(init_done), 48'd0);
      chk("rst_ex_ready", 48'(bus.ex_ready), 48'd0);
      chk("rst_col_ready", 48'(bus.col_ready), 48'd0);
      chk("rst_addr_err", 48'(addr_err), 48'd0);

      // init pass after release
      step();
      rst_n = 1'b1;
      base = cyc;
      push_init(base);
      wait_init(base);

      // earliest RUN write, then colour expansions
      do_ex(4'd7, 48'h123456789ABC);
      do_col(8'hE6, 48'h3FBFFF3FBFFF, 48'd50);
      do_col(8'h1B, 48'hBF3F00BF3F00, 48'd75);

      // both requesting for 4 cycles: execute wins every time
      bus.ex_valid = 1'b1; bus.col_valid = 1'b1; bus.col_code = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         bus.ex_addr = 4'(8 + i);
         bus.ex_data = 48'hC0DE00000000 + 48'(i);
         #1 chk("col_ready_starved", 48'(bus.col_ready), 48'd0);
         chk("ex_ready_pri", 48'(bus.ex_ready), 48'd1);
         push_wr(cyc + 1, 1'b0, 4'(8 + i), 48'hC0DE00000000 + 48'(i));
         step();
      end
      // execute drops out, the waiting colour request goes through
      bus.ex_valid = 1'b0;
      #1 chk("col_ready_free", 48'(bus.col_ready), 48'd1);
      push_wr(cyc + 1, 1'b0, 4'd4, 48'hFFFFFFFFFFFF);
      push_wr(cyc + 2, 1'b0, 4'd3, 48'd75);
      step();
      bus.col_valid = 1'b0;
      step();

      // out-of-range destinations, normal write in between
      do_ex(4'd14, 48'h00000000DEAD);
      do_ex(4'd5, 48'h00005555AAAA);
      do_ex(4'd15, 48'h000000000001);

      // init_start in RUN with an execute request offered
      bus.ex_valid = 1'b1; bus.ex_addr = 4'd2; bus.ex_data = 48'd1;
      init_start = 1'b1;
      #1 chk("ex_ready_init_start", 48'(bus.ex_ready), 48'd0);
      base = cyc + 1;
      push_init(base);
      step();
      init_start = 1'b0; bus.ex_valid = 1'b0;
      wait_init(base);

      // init_start while the r4 colour write is on the port: no r3 write
      bus.col_valid = 1'b1; bus.col_code = 8'hE6;
      #1 chk("col_ready_pre_abort", 48'(bus.col_ready), 48'd1);
      push_wr(cyc + 1, 1'b0, 4'd4, 48'h3FBFFF3FBFFF);
      step();
      bus.col_valid = 1'b0;
      init_start = 1'b1;
      base = cyc + 1;
      push_init(base);
      step();
      init_start = 1'b0;
      wait_init(base);

      // asynchronous reset mid-operation
      do_ex(4'd6, 48'h0000FEEDBEEF);
      #6;
      rst_n = 1'b0;
      #1;
      chk("async_we3", 48'(bus.we3), 48'd0);
      chk("async_ra3", 48'(bus.ra3), 48'd0);
      chk("async_wd3", bus.wd3, 48'd0);
      chk("async_init_done", 48'(init_done), 48'd0);
      step();
      rst_n = 1'b1;
      base = cyc;
      push_init(base);
      wait_init(base);
      do_ex(4'd1, 48'h000000000001);

      step();
      step();
      chk("queue_empty", 48'(q.size()), 48'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
